// File: rtl/act_unit.sv
// Two-stage activation pipeline (bypass/ReLU/leaky/bounded) over NumCh signed lanes, source mux, dual gated outputs.
// Latency 2 cycles in_fire -> out_valid; full valid/ready backpressure, each stage refills in the cycle it drains.
module act_unit #(
  parameter int                   DataWidth = 16,
  parameter int                   NumCh     = 4,
  parameter int                   LeakShift = 3,
  parameter logic [DataWidth-1:0] ClampMax  = 16'h0600,
  parameter int                   CntWidth  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DataWidth*NumCh-1:0] src1,
  input  logic [DataWidth*NumCh-1:0] src2,
  input  logic [1:0]                 sel_i,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       sel_o1,
  input  logic                       sel_o2,
  output logic [DataWidth*NumCh-1:0] out1,
  output logic [DataWidth*NumCh-1:0] out2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CntWidth-1:0]        sat_cnt,
  input  logic                       sat_clr
);

  localparam int BusW  = DataWidth * NumCh;
  localparam int ClipW = $clog2(NumCh + 1);
  localparam logic signed [DataWidth-1:0] ClampS = ClampMax;

  typedef enum logic [1:0] {
    ModeBypass = 2'b00,
    ModeRelu   = 2'b01,
    ModeLeaky  = 2'b10,
    ModeBound  = 2'b11
  } mode_e;

  logic                 s1_valid_q, s1_valid_d;
  logic [BusW-1:0]      s1_dat_q, s1_dat_d;
  mode_e                s1_mode_q, s1_mode_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [BusW-1:0]      s2_dat_q, s2_dat_d;
  logic [CntWidth-1:0]  sat_cnt_q, sat_cnt_d;

  logic                 in_fire;
  logic                 s2_load;
  logic [BusW-1:0]      act_dat;
  logic [ClipW-1:0]     clip_cnt;
  logic signed [DataWidth-1:0] lane, res;
  logic [CntWidth:0]    sat_sum;

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !rst && sel_i[1] && (!s1_valid_q || s2_load);
  assign in_fire  = in_valid && in_ready;

  // Stage 1 captures data and mode together so the mode travels with its beat.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_dat_d   = s1_dat_q;
    s1_mode_d  = s1_mode_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_dat_d   = sel_i[0] ? src2 : src1;
      s1_mode_d  = mode_e'(mode);
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    act_dat  = '0;
    clip_cnt = '0;
    lane     = '0;
    res      = '0;
    for (int k = 0; k < NumCh; k++) begin
      lane = $signed(s1_dat_q[k*DataWidth +: DataWidth]);
      res  = lane;
      case (s1_mode_q)
        ModeRelu:  if (lane < 0) res = '0;
        ModeLeaky: if (lane < 0) res = lane >>> LeakShift;
        ModeBound: begin
          if (lane < 0) begin
            res = '0;
          end else if (lane > ClampS) begin
            res      = ClampS;
            clip_cnt = clip_cnt + ClipW'(1);
          end
        end
        default: res = lane;
      endcase
      act_dat[k*DataWidth +: DataWidth] = res;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_dat_d   = s2_dat_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_dat_d   = act_dat;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Clip count saturates at all-ones; a clear wins over a same-cycle increment.
  always_comb begin
    sat_sum   = {1'b0, sat_cnt_q} + (CntWidth+1)'(clip_cnt);
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (s2_load && (s1_mode_q == ModeBound)) begin
      sat_cnt_d = sat_sum[CntWidth] ? '1 : sat_sum[CntWidth-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_dat_q   <= '0;
      s1_mode_q  <= ModeBypass;
      s2_valid_q <= 1'b0;
      s2_dat_q   <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dat_q   <= s1_dat_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_dat_q   <= s2_dat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out1      = sel_o1 ? s2_dat_q : '0;
  assign out2      = sel_o2 ? s2_dat_q : '0;
  assign out_valid = s2_valid_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_act_unit.sv
// Directed bench for act_unit: latency, activation modes, clip counter, backpressure, source select, async reset.
module tb_act_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] src1, src2;
  logic [1:0]  sel_i, mode;
  logic        in_valid, in_ready;
  logic        sel_o1, sel_o2;
  logic [63:0] out1, out2;
  logic        out_valid, out_ready;
  logic [15:0] sat_cnt;
  logic        sat_clr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  act_unit dut (
    .clk       (clk),
    .rst       (rst),
    .src1      (src1),
    .src2      (src2),
    .sel_i     (sel_i),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_o1    (sel_o1),
    .sel_o2    (sel_o2),
    .out1      (out1),
    .out2      (out2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_cnt   (sat_cnt),
    .sat_clr   (sat_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] lanes(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
    int          sent, rcvd, cyc;
    bit          saw_full, held;
    logic [63:0] held_dat;

    rst = 1'b1; src1 = '0; src2 = '0; sel_i = 2'b00; mode = 2'b00;
    in_valid = 1'b0; sel_o1 = 1'b0; sel_o2 = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("rst_out1", out1, 64'd0);
    rst = 1'b0;

    // Basic latency, ReLU
    step();
    sel_i = 2'b10; mode = 2'b01; sel_o1 = 1'b1; out_ready = 1'b1;
    src1 = lanes(-5, 7, 0, -32768); in_valid = 1'b1;
    #1 check("lat_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    #1 check("lat_cyc1_valid", 64'(out_valid), 64'd0);
    step();
    #1;
    check("lat_cyc2_valid", 64'(out_valid), 64'd1);
    check("relu_out1", out1, lanes(0, 7, 0, 0));
    check("relu_out2_gated", out2, 64'd0);
    step();
    #1 check("lat_drained", 64'(out_valid), 64'd0);

    // Leaky, then mode change with first beat in flight
    mode = 2'b10; src1 = lanes(-16, -1, 100, -9); in_valid = 1'b1;
    step();
    mode = 2'b01; src1 = lanes(-4, 5, -6, 7);
    step();
    in_valid = 1'b0; mode = 2'b00;
    #1 check("leaky_out1", out1, lanes(-2, -1, 100, -2));
    step();
    #1 check("relu_after_leaky", out1, lanes(0, 5, 0, 7));
    step();
    #1 check("leaky_drained", 64'(out_valid), 64'd0);

    // Bounded ReLU and clip counter
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0; mode = 2'b11; src1 = lanes('h0700, 'h0600, -3, 'h7FFF); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #1;
    check("bound_out1", out1, lanes('h0600, 'h0600, 0, 'h0600));
    check("bound_sat_cnt", 64'(sat_cnt), 64'd2);
    src1 = lanes('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF); in_valid = 1'b1;
    repeat (10) step();
    in_valid = 1'b0;
    repeat (3) step();
    #1 check("sat_cnt_accum", 64'(sat_cnt), 64'd42);
    in_valid = 1'b1;
    repeat (16400) step();
    in_valid = 1'b0;
    repeat (3) step();
    #1 check("sat_cnt_hold", 64'(sat_cnt), 64'hFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    #1;
    check("clr_beat_valid", 64'(out_valid), 64'd1);
    check("clr_priority", 64'(sat_cnt), 64'd0);
    step();

    // Backpressure stream of 8 beats
    mode = 2'b00; sel_i = 2'b10;
    sent = 0; rcvd = 0; cyc = 0; saw_full = 0; held = 0; held_dat = '0;
    while (rcvd < 8 && cyc < 200) begin
      out_ready = pat[cyc % 8][0];
      in_valid  = (sent < 8);
      src1      = lanes(sent + 1, 0, 0, sent + 1);
      #1;
      if (held) begin
        check("bp_stall_valid", 64'(out_valid), 64'd1);
        check("bp_stall_data", out1, held_dat);
      end
      if (in_valid && !in_ready) saw_full = 1;
      if (out_valid && out_ready) begin
        check("bp_order", out1, lanes(rcvd + 1, 0, 0, rcvd + 1));
        rcvd++;
      end
      held     = out_valid && !out_ready;
      held_dat = out1;
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_rcvd", 64'(rcvd), 64'd8);
    check("bp_sent", 64'(sent), 64'd8);
    check("bp_in_ready_drop", 64'(saw_full), 64'd1);
    repeat (3) step();
    #1 check("bp_no_dup", 64'(out_valid), 64'd0);

    // Source select
    sel_i = 2'b00; in_valid = 1'b1;
    #1 check("sel00_in_ready", 64'(in_ready), 64'd0);
    sel_i = 2'b01;
    #1 check("sel01_in_ready", 64'(in_ready), 64'd0);
    repeat (3) step();
    #1 check("sel0x_no_beat", 64'(out_valid), 64'd0);
    sel_i = 2'b11; mode = 2'b00; sel_o1 = 1'b1; sel_o2 = 1'b1;
    src1 = lanes(1, 2, 3, 4); src2 = lanes(-100, 200, -300, 'h7FFF);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    #1;
    check("src2_out1", out1, lanes(-100, 200, -300, 'h7FFF));
    check("src2_out2", out2, lanes(-100, 200, -300, 'h7FFF));
    sel_o1 = 1'b0;
    #1;
    check("gate_out1_off", out1, 64'd0);
    check("gate_out2_on", out2, lanes(-100, 200, -300, 'h7FFF));
    out_ready = 1'b1; sel_o1 = 1'b1;
    step();
    #1 check("src_drained", 64'(out_valid), 64'd0);

    // Async reset with two beats in flight
    out_ready = 1'b0; mode = 2'b11; sel_i = 2'b10;
    src1 = lanes('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF); in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_full", 64'(in_ready), 64'd0);
    check("pre_rst_sat", 64'(sat_cnt), 64'd4);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out1", out1, 64'd0);
    check("arst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    #1 check("post_rst_idle", 64'(out_valid), 64'd0);
    mode = 2'b00; src1 = lanes(9, -9, 0, 1); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #1;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data", out1, lanes(9, -9, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
